hazard_stall_unit: RTL and testbench

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 192 +++++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Decides, each cycle, whether the pipeline front end has to stall, flush or
// freeze, and tracks how long a data-memory access has been outstanding.
//
// Parameters
//   TIMEOUT_CYCLES  consecutive memory-wait cycles before the wait is aborted (1..255)
//
// Ports
//   clk, reset_n                       clock, synchronous active-low reset
//   id_rs1_addr_i, id_rs2_addr_i       source register indices of the ID instruction
//   id_rs1_used_i, id_rs2_used_i       ID instruction actually reads rs1 / rs2
//   ex_reg_wr_addr_i, ex_reg_wr_sig_i  destination and write enable of the EX instruction
//   ex_is_load_i                       EX instruction is a load
//   ex_br_taken_i                      branch/jump resolved taken in EX
//   mem_req_i, mem_ack_i               MEM stage access outstanding / completing
//   cnt_clr_i                          clear the stall-cycle counter
//   pc_stall_o, if_id_stall_o          hold PC and IF-ID register
//   id_ex_stall_o                      insert a bubble into ID-EX
//   if_id_flush_o, id_ex_flush_o       squash IF-ID / ID-EX
//   pipe_freeze_o                      hold ID-EX, EX-MEM and MEM-WB
//   state_o                            current state (RUN=00, WAIT=01, FLUSH=10)
//   mem_timeout_o                      sticky memory-abort flag
//   stall_cnt_o                        saturating count of PC-stall cycles
module hazard_stall_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_reg_wr_addr_i,
  input  logic        ex_reg_wr_sig_i,
  input  logic        ex_is_load_i,
  input  logic        ex_br_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        cnt_clr_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        pipe_freeze_o,
  output logic [1:0]  state_o,
  output logic        mem_timeout_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_WAIT    = 2'b01,
    S_FLUSH   = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_waitCnt;
  logic [7:0]  w_nextWaitCnt;
  logic [8:0]  w_waitInc;
  logic        w_setTimeout;
  logic        w_loadUse;
  logic        w_memWait;
  logic        r_memTimeout;
  logic [15:0] r_stallCnt;

  // A load whose destination is read by the ID instruction cannot forward in
  // time; writes to x0 never create a dependency.
  assign w_loadUse = ex_is_load_i & ex_reg_wr_sig_i & (ex_reg_wr_addr_i != 5'd0) &
                     ((id_rs1_used_i & (id_rs1_addr_i == ex_reg_wr_addr_i)) |
                      (id_rs2_used_i & (id_rs2_addr_i == ex_reg_wr_addr_i)));

  assign w_memWait = mem_req_i & ~mem_ack_i;

  // Nine bits so the increment never wraps before it is compared with the limit.
  assign w_waitInc = {1'b0, r_waitCnt} + 9'd1;

  // Next-state and output decode. Memory wait dominates a taken branch, which
  // dominates a load-use bubble. The wait counter already counts the cycle
  // that entered WAIT, so the abort fires on the cycle whose incremented
  // count reaches the limit, giving exactly TIMEOUT_CYCLES frozen cycles.
  always_comb begin
    w_nextState   = S_RUN;
    w_nextWaitCnt = 8'd0;
    w_setTimeout  = 1'b0;
    pc_stall_o    = 1'b0;
    if_id_stall_o = 1'b0;
    id_ex_stall_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    pipe_freeze_o = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_memWait) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          pipe_freeze_o = 1'b1;
          w_nextState   = S_WAIT;
          w_nextWaitCnt = 8'd1;
        end else if (ex_br_taken_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          w_nextState   = S_FLUSH;
        end else if (w_loadUse) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          id_ex_stall_o = 1'b1;
        end
      end

      S_WAIT: begin
        if (!mem_ack_i) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          pipe_freeze_o = 1'b1;
          if (w_waitInc >= TIMEOUT_LIM) begin
            w_setTimeout = 1'b1;
          end else begin
            w_nextState   = S_WAIT;
            w_nextWaitCnt = w_waitInc[7:0];
          end
        end
      end

      S_FLUSH: begin
        if (w_memWait) begin
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          pipe_freeze_o = 1'b1;
          w_nextState   = S_WAIT;
          w_nextWaitCnt = 8'd1;
        end
      end

      default: begin
        w_nextState = S_RUN;
      end
    endcase

    // Reset silences every pipeline control regardless of state or inputs.
    if (!reset_n) begin
      pc_stall_o    = 1'b0;
      if_id_stall_o = 1'b0;
      id_ex_stall_o = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      pipe_freeze_o = 1'b0;
      w_setTimeout  = 1'b0;
    end
  end

  // State and wait counter; a reset during WAIT simply drops the wait.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_RUN;
      r_waitCnt <= 8'd0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
    end
  end

  // Sticky abort flag: only reset clears it, the counter clear leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_memTimeout <= 1'b0;
    end else if (w_setTimeout) begin
      r_memTimeout <= 1'b1;
    end
  end

  // Saturating stall-cycle counter; an explicit clear beats an increment.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stallCnt <= 16'd0;
    end else if (cnt_clr_i) begin
      r_stallCnt <= 16'd0;
    end else if (pc_stall_o && (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign state_o       = r_state;
  assign mem_timeout_o = r_memTimeout;
  assign stall_cnt_o   = r_stallCnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit
// Directed bench for hazard_stall_unit built with TIMEOUT_CYCLES=4. Inputs are
// changed 1 ns after a rising edge, combinational outputs are sampled 1 ns
// later, and registered outputs are sampled 1 ns after the following edge.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic [4:0]  ex_reg_wr_addr_i;
  logic        ex_reg_wr_sig_i;
  logic        ex_is_load_i;
  logic        ex_br_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        cnt_clr_i;
  logic        pc_stall_o;
  logic        if_id_stall_o;
  logic        id_ex_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        pipe_freeze_o;
  logic [1:0]  state_o;
  logic        mem_timeout_o;
  logic [15:0] stall_cnt_o;

  logic [5:0]  ctl;
  int          testsRun = 0;
  int          testsFailed = 0;

  // Control bits packed as {pc, if_id, id_ex stall, if_id, id_ex flush, freeze}.
  assign ctl = {pc_stall_o, if_id_stall_o, id_ex_stall_o,
                if_id_flush_o, id_ex_flush_o, pipe_freeze_o};

  hazard_stall_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .id_rs1_addr_i    (id_rs1_addr_i),
    .id_rs2_addr_i    (id_rs2_addr_i),
    .id_rs1_used_i    (id_rs1_used_i),
    .id_rs2_used_i    (id_rs2_used_i),
    .ex_reg_wr_addr_i (ex_reg_wr_addr_i),
    .ex_reg_wr_sig_i  (ex_reg_wr_sig_i),
    .ex_is_load_i     (ex_is_load_i),
    .ex_br_taken_i    (ex_br_taken_i),
    .mem_req_i        (mem_req_i),
    .mem_ack_i        (mem_ack_i),
    .cnt_clr_i        (cnt_clr_i),
    .pc_stall_o       (pc_stall_o),
    .if_id_stall_o    (if_id_stall_o),
    .id_ex_stall_o    (id_ex_stall_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_flush_o    (id_ex_flush_o),
    .pipe_freeze_o    (pipe_freeze_o),
    .state_o          (state_o),
    .mem_timeout_o    (mem_timeout_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Drive one input vector and let the combinational outputs settle.
  task automatic applyStimulus(input logic isLoad, input logic [4:0] wrAddr,
                               input logic [4:0] rs1, input logic rs1Used,
                               input logic [4:0] rs2, input logic rs2Used,
                               input logic br, input logic req, input logic ack);
    ex_is_load_i     = isLoad;
    ex_reg_wr_sig_i  = 1'b1;
    ex_reg_wr_addr_i = wrAddr;
    id_rs1_addr_i    = rs1;
    id_rs1_used_i    = rs1Used;
    id_rs2_addr_i    = rs2;
    id_rs2_used_i    = rs2Used;
    ex_br_taken_i    = br;
    mem_req_i        = req;
    mem_ack_i        = ack;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    cnt_clr_i = 1'b0;
    reset_n   = 1'b0;

    // Reset with hazards present on the inputs: nothing may be asserted.
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("reset_ctl", 16'(ctl), 16'h0);
    nextCycle();
    checkOutput("reset_state", 16'(state_o), 16'h0);
    checkOutput("reset_cnt", stall_cnt_o, 16'h0);
    checkOutput("reset_timeout", 16'(mem_timeout_o), 16'h0);
    reset_n = 1'b1;

    // Load-use through rs2.
    applyStimulus(1'b1, 5'd5, 5'd3, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2_ctl", 16'(ctl), 16'h38);
    checkOutput("lu_rs2_state", 16'(state_o), 16'h0);
    nextCycle();
    checkOutput("lu_rs2_cnt", stall_cnt_o, 16'd1);
    checkOutput("lu_rs2_state_after", 16'(state_o), 16'h0);

    // Load-use through rs1.
    applyStimulus(1'b1, 5'd7, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1_ctl", 16'(ctl), 16'h38);
    nextCycle();
    checkOutput("lu_rs1_cnt", stall_cnt_o, 16'd2);

    // Matching index but operand not read, non-load producer, load to x0.
    applyStimulus(1'b1, 5'd9, 5'd1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_unused_ctl", 16'(ctl), 16'h0);
    applyStimulus(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nonload_ctl", 16'(ctl), 16'h0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("x0_ctl", 16'(ctl), 16'h0);
    nextCycle();
    checkOutput("x0_cnt", stall_cnt_o, 16'd2);

    // Clear the counter, then a memory wait acknowledged on its fourth cycle.
    cnt_clr_i = 1'b1;
    idle();
    nextCycle();
    cnt_clr_i = 1'b0;
    checkOutput("clr_cnt", stall_cnt_o, 16'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mw1_ctl", 16'(ctl), 16'h31);
    checkOutput("mw1_state", 16'(state_o), 16'h0);
    nextCycle();
    checkOutput("mw2_ctl", 16'(ctl), 16'h31);
    checkOutput("mw2_state", 16'(state_o), 16'h1);
    nextCycle();
    checkOutput("mw3_ctl", 16'(ctl), 16'h31);
    checkOutput("mw3_state", 16'(state_o), 16'h1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_ack_ctl", 16'(ctl), 16'h0);
    checkOutput("mw_ack_state", 16'(state_o), 16'h1);
    nextCycle();
    idle();
    checkOutput("mw_done_state", 16'(state_o), 16'h0);
    checkOutput("mw_done_cnt", stall_cnt_o, 16'd3);

    // Branch and load-use together: flush only; load-use masked in FLUSH.
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_lu_ctl", 16'(ctl), 16'h06);
    nextCycle();
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_state", 16'(state_o), 16'h2);
    checkOutput("flush_masked_ctl", 16'(ctl), 16'h0);
    nextCycle();
    idle();
    checkOutput("flush_exit_state", 16'(state_o), 16'h0);
    checkOutput("flush_cnt", stall_cnt_o, 16'd3);

    // Memory wait arriving during FLUSH is still honoured.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_mw_ctl", 16'(ctl), 16'h31);
    nextCycle();
    checkOutput("flush_mw_state", 16'(state_o), 16'h1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    checkOutput("flush_mw_cnt", stall_cnt_o, 16'd4);

    // Memory wait beats branch and load-use in RUN.
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("prio_ctl", 16'(ctl), 16'h31);
    nextCycle();
    checkOutput("prio_state", 16'(state_o), 16'h1);
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("prio_ack_ctl", 16'(ctl), 16'h0);
    nextCycle();
    checkOutput("prio_ack_state", 16'(state_o), 16'h0);
    checkOutput("prio_cnt", stall_cnt_o, 16'd5);

    // Clear wins over a simultaneous stall increment.
    cnt_clr_i = 1'b1;
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_lu_ctl", 16'(ctl), 16'h38);
    nextCycle();
    cnt_clr_i = 1'b0;
    checkOutput("clr_win_cnt", stall_cnt_o, 16'd0);

    // Timeout after four frozen cycles with no acknowledge.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("to_a_state", 16'(state_o), 16'h0);
    nextCycle();
    checkOutput("to_b_state", 16'(state_o), 16'h1);
    nextCycle();
    checkOutput("to_c_state", 16'(state_o), 16'h1);
    nextCycle();
    checkOutput("to_d_state", 16'(state_o), 16'h1);
    checkOutput("to_d_ctl", 16'(ctl), 16'h31);
    checkOutput("to_d_flag", 16'(mem_timeout_o), 16'h0);
    nextCycle();
    idle();
    checkOutput("to_state", 16'(state_o), 16'h0);
    checkOutput("to_flag", 16'(mem_timeout_o), 16'h1);
    checkOutput("to_ctl", 16'(ctl), 16'h0);
    checkOutput("to_cnt", stall_cnt_o, 16'd4);
    cnt_clr_i = 1'b1;
    nextCycle();
    cnt_clr_i = 1'b0;
    checkOutput("to_clr_cnt", stall_cnt_o, 16'd0);
    checkOutput("to_clr_flag", 16'(mem_timeout_o), 16'h1);

    // Long unacknowledged request stalls every cycle and saturates the counter.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (65540) nextCycle();
    checkOutput("sat_cnt", stall_cnt_o, 16'hFFFF);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_run_state", 16'(state_o), 16'h0);
    checkOutput("sat_run_ctl", 16'(ctl), 16'h31);
    nextCycle();
    checkOutput("sat_hold_cnt", stall_cnt_o, 16'hFFFF);
    checkOutput("sat_wait_state", 16'(state_o), 16'h1);

    // Reset in the middle of WAIT.
    reset_n = 1'b0;
    #1;
    checkOutput("rst_wait_ctl", 16'(ctl), 16'h0);
    nextCycle();
    checkOutput("rst_wait_state", 16'(state_o), 16'h0);
    checkOutput("rst_wait_cnt", stall_cnt_o, 16'h0);
    checkOutput("rst_wait_flag", 16'(mem_timeout_o), 16'h0);
    reset_n = 1'b1;
    idle();
    nextCycle();
    checkOutput("post_rst_state", 16'(state_o), 16'h0);
    checkOutput("post_rst_ctl", 16'(ctl), 16'h0);
    checkOutput("post_rst_flag", 16'(mem_timeout_o), 16'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
